pio_bus_master: RTL and testbench

Avalon-MM initiator that issues single-word write and read transactions to the memory-mapped PIO slaves in the Computer_System (chipselect / write_n / read_n style ports, 2-bit word address, 32-bit data). It accepts one command at a time from a local valid/ready command port and drives the bus. It returns write completions and read data on a valid/ready response port. It sits between radar control logic and PIO slaves such as the Arduino reset output, so fabric logic can program the PIOs without the Nios processor.

---
 rtl/pio_bus_master_if.sv | 43 ++++
 rtl/pio_bus_master.sv | 119 +++++++++++
 tb/tb_pio_bus_master.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pio_bus_master_if.sv
// Command, response and Avalon-MM signal bundle for pio_bus_master.
// master: the bus master's view; slave: the command source / bus slave side.
interface pio_bus_master_if #(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 32
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_address;
    logic [DATA_W-1:0] cmd_writedata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_readdata;
    logic              rsp_error;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_chipselect;
    logic              avm_write_n;
    logic              avm_read_n;
    logic [DATA_W-1:0] avm_writedata;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_waitrequest;

    modport master (
        input  cmd_valid, cmd_write, cmd_address, cmd_writedata,
        input  rsp_ready,
        input  avm_readdata, avm_waitrequest,
        output cmd_ready,
        output rsp_valid, rsp_readdata, rsp_error,
        output avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_address, cmd_writedata,
        output rsp_ready,
        output avm_readdata, avm_waitrequest,
        input  cmd_ready,
        input  rsp_valid, rsp_readdata, rsp_error,
        input  avm_address, avm_chipselect, avm_write_n, avm_read_n, avm_writedata
    );
endinterface

// File: rtl/pio_bus_master.sv
// Single-outstanding Avalon-MM initiator for chipselect/write_n/read_n PIO slaves.
// Optional feature macro: PIO_BUS_MASTER_TIMEOUT_EN aborts an access after TIMEOUT
// consecutive waitrequest cycles and reports it through rsp_error.
module pio_bus_master #(
    parameter int ADDR_W       = 2,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 0,
    parameter int TIMEOUT      = 255
) (
    input logic              clk,
    input logic              reset,
    pio_bus_master_if.master bus
);
    localparam int LAT_W = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAccess, StRdWait, StResp} state_e;

    state_e           state_q;
    logic             cmd_write_q;
    logic [LAT_W-1:0] lat_cnt_q;

`ifdef PIO_BUS_MASTER_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    logic [TO_W-1:0] stall_cnt_q;
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT >= 1);
`endif

    // Transaction FSM; every interface output is a flop updated here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= StIdle;
            cmd_write_q        <= 1'b0;
            lat_cnt_q          <= '0;
            bus.cmd_ready      <= 1'b1;
            bus.rsp_valid      <= 1'b0;
            bus.rsp_readdata   <= {DATA_W{1'b0}};
            bus.rsp_error      <= 1'b0;
            bus.avm_address    <= {ADDR_W{1'b0}};
            bus.avm_chipselect <= 1'b0;
            bus.avm_write_n    <= 1'b1;
            bus.avm_read_n     <= 1'b1;
            bus.avm_writedata  <= {DATA_W{1'b0}};
`ifdef PIO_BUS_MASTER_TIMEOUT_EN
            stall_cnt_q        <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        cmd_write_q        <= bus.cmd_write;
                        bus.avm_address    <= bus.cmd_address;
                        bus.avm_writedata  <= bus.cmd_writedata;
                        bus.avm_chipselect <= 1'b1;
                        bus.avm_write_n    <= ~bus.cmd_write;
                        bus.avm_read_n     <= bus.cmd_write;
                        bus.cmd_ready      <= 1'b0;
                        state_q            <= StAccess;
`ifdef PIO_BUS_MASTER_TIMEOUT_EN
                        stall_cnt_q        <= '0;
`endif
                    end
                end
                StAccess: begin
                    if (!bus.avm_waitrequest) begin
                        bus.avm_chipselect <= 1'b0;
                        bus.avm_write_n    <= 1'b1;
                        bus.avm_read_n     <= 1'b1;
                        bus.rsp_error      <= 1'b0;
                        if (cmd_write_q) begin
                            bus.rsp_readdata <= {DATA_W{1'b0}};
                            bus.rsp_valid    <= 1'b1;
                            state_q          <= StResp;
                        end else if (READ_LATENCY == 0) begin
                            bus.rsp_readdata <= bus.avm_readdata;
                            bus.rsp_valid    <= 1'b1;
                            state_q          <= StResp;
                        end else begin
                            lat_cnt_q <= LAT_W'(READ_LATENCY);
                            state_q   <= StRdWait;
                        end
                    end
`ifdef PIO_BUS_MASTER_TIMEOUT_EN
                    // The stall that would make TIMEOUT consecutive cycles aborts.
                    else if (stall_cnt_q == TO_W'(TIMEOUT - 1)) begin
                        bus.avm_chipselect <= 1'b0;
                        bus.avm_write_n    <= 1'b1;
                        bus.avm_read_n     <= 1'b1;
                        bus.rsp_readdata   <= {DATA_W{1'b0}};
                        bus.rsp_error      <= 1'b1;
                        bus.rsp_valid      <= 1'b1;
                        state_q            <= StResp;
                    end else begin
                        stall_cnt_q <= stall_cnt_q + 1'b1;
                    end
`endif
                end
                StRdWait: begin
                    if (lat_cnt_q == LAT_W'(1)) begin
                        bus.rsp_readdata <= bus.avm_readdata;
                        bus.rsp_valid    <= 1'b1;
                        state_q          <= StResp;
                    end else begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end
                end
                StResp: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state_q       <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: tb/tb_pio_bus_master.sv
// Directed bench for pio_bus_master: dut_a has READ_LATENCY=0, dut_b READ_LATENCY=2,
// both TIMEOUT=4. Inputs are driven and outputs sampled 1 time unit after posedge.
module tb_pio_bus_master;
    localparam logic [31:0] JUNK = 32'h0BAD_0BAD;

    logic clk;
    logic reset;

    pio_bus_master_if #(.ADDR_W(2), .DATA_W(32)) a ();
    pio_bus_master_if #(.ADDR_W(2), .DATA_W(32)) b ();

    pio_bus_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(0), .TIMEOUT(4)) dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a)
    );

    pio_bus_master #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(2), .TIMEOUT(4)) dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stalls;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_a(input string tag);
        check({tag, ".cmd_ready"}, 32'(a.cmd_ready), 32'd1);
        check({tag, ".rsp_valid"}, 32'(a.rsp_valid), 32'd0);
        check({tag, ".rsp_readdata"}, a.rsp_readdata, 32'd0);
        check({tag, ".rsp_error"}, 32'(a.rsp_error), 32'd0);
        check({tag, ".chipselect"}, 32'(a.avm_chipselect), 32'd0);
        check({tag, ".write_n"}, 32'(a.avm_write_n), 32'd1);
        check({tag, ".read_n"}, 32'(a.avm_read_n), 32'd1);
        check({tag, ".address"}, 32'(a.avm_address), 32'd0);
        check({tag, ".writedata"}, a.avm_writedata, 32'd0);
    endtask

    // One dut_a transaction with rsp_ready held high, checked cycle by cycle.
    task automatic run_a(input vec_t v, input string tag);
        check({tag, ".idle_ready"}, 32'(a.cmd_ready), 32'd1);
        a.cmd_valid       = 1'b1;
        a.cmd_write       = v.wr;
        a.cmd_address     = v.addr;
        a.cmd_writedata   = v.wdata;
        a.avm_waitrequest = (v.stalls > 0);
        a.avm_readdata    = (v.stalls > 0) ? JUNK : v.rdata;
        a.rsp_ready       = 1'b1;
        tick();
        a.cmd_valid     = 1'b0;
        a.cmd_address   = ~v.addr;
        a.cmd_writedata = JUNK;
        check({tag, ".cs"}, 32'(a.avm_chipselect), 32'd1);
        check({tag, ".write_n"}, 32'(a.avm_write_n), 32'(!v.wr));
        check({tag, ".read_n"}, 32'(a.avm_read_n), 32'(v.wr));
        check({tag, ".address"}, 32'(a.avm_address), 32'(v.addr));
        check({tag, ".writedata"}, a.avm_writedata, v.wdata);
        check({tag, ".cmd_ready_low"}, 32'(a.cmd_ready), 32'd0);
        for (int i = 0; i < v.stalls; i++) begin
            tick();
            check($sformatf("%s.stall%0d_cs", tag, i), 32'(a.avm_chipselect), 32'd1);
            check($sformatf("%s.stall%0d_valid", tag, i), 32'(a.rsp_valid), 32'd0);
        end
        a.avm_waitrequest = 1'b0;
        a.avm_readdata    = v.rdata;
        tick();
        a.avm_readdata = JUNK;
        check({tag, ".rsp_valid"}, 32'(a.rsp_valid), 32'd1);
        check({tag, ".cs_off"}, 32'(a.avm_chipselect), 32'd0);
        check({tag, ".strobes_off"}, {30'd0, a.avm_write_n, a.avm_read_n}, 32'd3);
        check({tag, ".rsp_readdata"}, a.rsp_readdata, v.exp_rdata);
        check({tag, ".rsp_error"}, 32'(a.rsp_error), 32'd0);
        tick();
        check({tag, ".consumed"}, 32'(a.rsp_valid), 32'd0);
        check({tag, ".ready_back"}, 32'(a.cmd_ready), 32'd1);
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{wr: 1'b1, addr: 2'd0, wdata: 32'h1,         rdata: JUNK,
                    stalls: 0, exp_rdata: 32'h0};
        vecs[1] = '{wr: 1'b0, addr: 2'd0, wdata: 32'h0,         rdata: 32'h0000_0001,
                    stalls: 0, exp_rdata: 32'h0000_0001};
        vecs[2] = '{wr: 1'b1, addr: 2'd3, wdata: 32'hDEAD_BEEF, rdata: JUNK,
                    stalls: 2, exp_rdata: 32'h0};
        vecs[3] = '{wr: 1'b0, addr: 2'd2, wdata: 32'h7,         rdata: 32'hA5A5_5A5A,
                    stalls: 1, exp_rdata: 32'hA5A5_5A5A};
        vecs[4] = '{wr: 1'b1, addr: 2'd1, wdata: 32'h0,         rdata: 32'h1234,
                    stalls: 0, exp_rdata: 32'h0};
        vecs[5] = '{wr: 1'b0, addr: 2'd1, wdata: 32'h3,         rdata: 32'hFFFF_FFFF,
                    stalls: 3, exp_rdata: 32'hFFFF_FFFF};

        reset = 1'b1;
        a.cmd_valid = 1'b0; a.cmd_write = 1'b0; a.cmd_address = '0; a.cmd_writedata = '0;
        a.rsp_ready = 1'b1; a.avm_readdata = '0; a.avm_waitrequest = 1'b0;
        b.cmd_valid = 1'b0; b.cmd_write = 1'b0; b.cmd_address = '0; b.cmd_writedata = '0;
        b.rsp_ready = 1'b1; b.avm_readdata = '0; b.avm_waitrequest = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_a("init");
        check("init_b.cmd_ready", 32'(b.cmd_ready), 32'd1);
        check("init_b.cs", 32'(b.avm_chipselect), 32'd0);
        check("init_b.read_n", 32'(b.avm_read_n), 32'd1);

        for (int i = 0; i < 6; i++) run_a(vecs[i], $sformatf("vec%0d", i));
        check("addr_held_idle", 32'(a.avm_address), 32'd1);
        check("wdata_held_idle", a.avm_writedata, 32'h3);

`ifdef PIO_BUS_MASTER_TIMEOUT_EN
        // Waitrequest stuck: four strobed cycles, then abort with error.
        a.cmd_valid = 1'b1; a.cmd_write = 1'b0; a.cmd_address = 2'd2;
        a.avm_waitrequest = 1'b1; a.avm_readdata = JUNK;
        tick();
        a.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("to.cs%0d", i), 32'(a.avm_chipselect), 32'd1);
            if (i < 3) tick();
        end
        tick();
        check("to.cs_off", 32'(a.avm_chipselect), 32'd0);
        check("to.read_n", 32'(a.avm_read_n), 32'd1);
        check("to.rsp_valid", 32'(a.rsp_valid), 32'd1);
        check("to.rsp_error", 32'(a.rsp_error), 32'd1);
        check("to.rsp_readdata", a.rsp_readdata, 32'd0);
        a.avm_waitrequest = 1'b0;
        tick();
        check("to.consumed", 32'(a.rsp_valid), 32'd0);
`else
        // No timeout: a long stall still completes normally.
        run_a('{wr: 1'b0, addr: 2'd2, wdata: 32'h0, rdata: 32'h0000_00C3,
                stalls: 10, exp_rdata: 32'h0000_00C3}, "long_stall");
`endif

        // READ_LATENCY=2 with 3 stalls on dut_b: strobe 4 cycles, valid at N+7.
        b.cmd_valid = 1'b1; b.cmd_write = 1'b0; b.cmd_address = 2'd2;
        b.avm_waitrequest = 1'b1; b.avm_readdata = JUNK;
        tick();
        b.cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lat.read_n%0d", i), 32'(b.avm_read_n), 32'd0);
            if (i == 3) b.avm_waitrequest = 1'b0;
            else tick();
        end
        tick();
        check("lat.read_n_off", 32'(b.avm_read_n), 32'd1);
        check("lat.cs_off", 32'(b.avm_chipselect), 32'd0);
        check("lat.valid_n5", 32'(b.rsp_valid), 32'd0);
        tick();
        check("lat.valid_n6", 32'(b.rsp_valid), 32'd0);
        b.avm_readdata = 32'h5EED_0002;
        tick();
        b.avm_readdata = JUNK;
        check("lat.valid_n7", 32'(b.rsp_valid), 32'd1);
        check("lat.rdata", b.rsp_readdata, 32'h5EED_0002);
        tick();
        check("lat.consumed", 32'(b.rsp_valid), 32'd0);

        // Response backpressure: response held, next command waits for the IDLE cycle.
        a.cmd_valid = 1'b1; a.cmd_write = 1'b0; a.cmd_address = 2'd1;
        a.avm_readdata = 32'h1234_5678; a.rsp_ready = 1'b0;
        tick();
        a.cmd_write = 1'b1; a.cmd_address = 2'd3; a.cmd_writedata = 32'h55;
        tick();
        a.avm_readdata = JUNK;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("bp.valid%0d", i), 32'(a.rsp_valid), 32'd1);
            check($sformatf("bp.rdata%0d", i), a.rsp_readdata, 32'h1234_5678);
            check($sformatf("bp.cmd_ready%0d", i), 32'(a.cmd_ready), 32'd0);
            check($sformatf("bp.cs%0d", i), 32'(a.avm_chipselect), 32'd0);
            if (i == 4) a.rsp_ready = 1'b1;
            tick();
        end
        check("bp.released", 32'(a.rsp_valid), 32'd0);
        check("bp.idle_ready", 32'(a.cmd_ready), 32'd1);
        check("bp.not_yet", 32'(a.avm_chipselect), 32'd0);
        tick();
        a.cmd_valid = 1'b0;
        check("bp.accept_cs", 32'(a.avm_chipselect), 32'd1);
        check("bp.accept_wr", 32'(a.avm_write_n), 32'd0);
        check("bp.accept_addr", 32'(a.avm_address), 32'd3);
        check("bp.accept_wdata", a.avm_writedata, 32'h55);
        tick();
        check("bp.wr_rsp", 32'(a.rsp_valid), 32'd1);
        check("bp.wr_rdata", a.rsp_readdata, 32'd0);
        tick();

        // Reset while in RESP.
        a.cmd_valid = 1'b1; a.cmd_write = 1'b0; a.cmd_address = 2'd2;
        a.avm_readdata = 32'hCAFE_F00D; a.rsp_ready = 1'b0;
        tick();
        a.cmd_valid = 1'b0;
        tick();
        check("rr.valid", 32'(a.rsp_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_reset_a("rst_resp");

        // Reset while in ACCESS with the slave stalling.
        a.rsp_ready = 1'b1;
        a.cmd_valid = 1'b1; a.cmd_write = 1'b1; a.cmd_address = 2'd3;
        a.cmd_writedata = 32'h77; a.avm_waitrequest = 1'b1;
        tick();
        a.cmd_valid = 1'b0;
        check("ra.cs", 32'(a.avm_chipselect), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        a.avm_waitrequest = 1'b0;
        check_reset_a("rst_access");

        run_a('{wr: 1'b0, addr: 2'd3, wdata: 32'h9, rdata: 32'h0000_0042,
                stalls: 0, exp_rdata: 32'h0000_0042}, "after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
